// File: rtl/seg_scan_if.sv
// seg_scan_if: control and display signals between the stopwatch datapath
// and the seven-segment scan controller.
//   master : drives enable, brightness, lzb_en, BCD0..BCD3; receives scan outputs
//   slave  : the scan controller; receives the controls, drives
//            refresh_counter (digit index), an (active-low anodes),
//            digit_blank (leading-zero suppression), frame_tick (frame start)
interface seg_scan_if;
    logic       enable;
    logic [3:0] brightness;
    logic       lzb_en;
    logic [3:0] BCD0;
    logic [3:0] BCD1;
    logic [3:0] BCD2;
    logic [3:0] BCD3;
    logic [1:0] refresh_counter;
    logic [3:0] an;
    logic       digit_blank;
    logic       frame_tick;

    modport master (
        output enable, brightness, lzb_en, BCD0, BCD1, BCD2, BCD3,
        input  refresh_counter, an, digit_blank, frame_tick
    );

    modport slave (
        input  enable, brightness, lzb_en, BCD0, BCD1, BCD2, BCD3,
        output refresh_counter, an, digit_blank, frame_tick
    );
endinterface

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed scan of a 4-digit seven-segment
// display. Each digit slot is REFRESH_DIV cycles: a blanking gap of
// BLANK_CYCLES with all anodes off, then a brightness-scaled on window,
// then off for the rest of the slot. Optional leading-zero blanking keeps
// the anode off for suppressed digits.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : seg_scan_if.slave (enable, brightness, lzb_en, BCD0..3 in;
//           refresh_counter, an, digit_blank, frame_tick out; all registered)
module seg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic      clk,
    input  logic      reset,
    seg_scan_if.slave bus
);
    localparam int ON_STEP = (REFRESH_DIV - BLANK_CYCLES) / 16;
    // One extra bit so BLANK_CYCLES + on_len cannot overflow when it equals 2^CNT_W
    localparam int LEN_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [LEN_W-1:0] BLANK_LEN = LEN_W'(BLANK_CYCLES);
    localparam logic [LEN_W-1:0] STEP_LEN  = LEN_W'(ON_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2,
        ST_OFF   = 2'd3
    } state_t;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_slot_cnt, w_slot_cnt_n;
    logic [1:0]       r_idx, w_idx_n;
    logic [LEN_W-1:0] r_on_len, w_on_len_n;
    logic             r_blank, w_blank_n;
    logic [3:0]       r_an, w_an_n;
    logic             r_tick, w_tick_n;
    logic             w_run_n;
    logic             w_start;

    // Leading-zero decision for digit idx: suppressed only when it and every
    // more significant digit are zero; digit 0 always shows.
    function automatic logic lzb_blank(input logic [1:0] idx, input logic en,
                                       input logic [3:0] d1, input logic [3:0] d2,
                                       input logic [3:0] d3);
        logic z3;
        logic z2;
        logic z1;
        logic res;
        z3 = (d3 == 4'd0);
        z2 = z3 & (d2 == 4'd0);
        z1 = z2 & (d1 == 4'd0);
        case (idx)
            2'd3:    res = z3;
            2'd2:    res = z2;
            2'd1:    res = z1;
            default: res = 1'b0;
        endcase
        return en & res;
    endfunction

    // Next-state, next-slot and next-output logic; outputs are computed from
    // the next state so the registered outputs line up with the state.
    always_comb begin
        w_run_n      = 1'b0;
        w_start      = 1'b0;
        w_slot_cnt_n = '0;
        w_idx_n      = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable) begin
                    w_run_n = 1'b1;
                    w_start = 1'b1;
                end else begin
                    w_run_n = 1'b0;
                end
            end
            ST_BLANK, ST_ON, ST_OFF: begin
                if (!bus.enable) begin
                    w_run_n = 1'b0;
                end else if (r_slot_cnt == SLOT_LAST) begin
                    w_run_n = 1'b1;
                    w_start = 1'b1;
                    w_idx_n = r_idx + 2'd1;
                end else begin
                    w_run_n      = 1'b1;
                    w_slot_cnt_n = r_slot_cnt + CNT_W'(1);
                    w_idx_n      = r_idx;
                end
            end
            default: begin
                w_run_n = 1'b0;
            end
        endcase

        // Slot attributes are captured only on entry to a new slot
        if (!w_run_n) begin
            w_on_len_n = r_on_len;
            w_blank_n  = 1'b0;
        end else if (w_start) begin
            w_on_len_n = LEN_W'({1'b0, bus.brightness} + 5'd1) * STEP_LEN;
            w_blank_n  = lzb_blank(w_idx_n, bus.lzb_en, bus.BCD1, bus.BCD2, bus.BCD3);
        end else begin
            w_on_len_n = r_on_len;
            w_blank_n  = r_blank;
        end

        if (!w_run_n) begin
            w_state_n = ST_IDLE;
        end else if ({1'b0, w_slot_cnt_n} < BLANK_LEN) begin
            w_state_n = ST_BLANK;
        end else if ({1'b0, w_slot_cnt_n} < (BLANK_LEN + w_on_len_n)) begin
            w_state_n = ST_ON;
        end else begin
            w_state_n = ST_OFF;
        end

        if ((w_state_n == ST_ON) && !w_blank_n) begin
            w_an_n = ~(4'b0001 << w_idx_n);
        end else begin
            w_an_n = 4'b1111;
        end

        w_tick_n = w_run_n & w_start & (w_idx_n == 2'd0);
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_slot_cnt <= '0;
            r_idx      <= 2'd0;
            r_on_len   <= '0;
            r_blank    <= 1'b0;
            r_an       <= 4'b1111;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_slot_cnt <= w_slot_cnt_n;
            r_idx      <= w_idx_n;
            r_on_len   <= w_on_len_n;
            r_blank    <= w_blank_n;
            r_an       <= w_an_n;
            r_tick     <= w_tick_n;
        end
    end

    assign bus.refresh_counter = r_idx;
    assign bus.an              = r_an;
    assign bus.digit_blank     = r_blank;
    assign bus.frame_tick      = r_tick;
endmodule
